// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART request/response controller:
// FSM state encoding, response codes and timer sizing helper.
package uart_cmd_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_ADDR  = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_RSP  = 3'd3;
  localparam logic [2:0] ST_SEND_CODE = 3'd4;
  localparam logic [2:0] ST_WAIT_CODE = 3'd5;
  localparam logic [2:0] ST_SEND_DATA = 3'd6;
  localparam logic [2:0] ST_WAIT_DATA = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    GET_ADDR  = ST_GET_ADDR,
    ISSUE     = ST_ISSUE,
    WAIT_RSP  = ST_WAIT_RSP,
    SEND_CODE = ST_SEND_CODE,
    WAIT_CODE = ST_WAIT_CODE,
    SEND_DATA = ST_SEND_DATA,
    WAIT_DATA = ST_WAIT_DATA
  } state_t;

  localparam logic [7:0] RSP_BAD_ADDR = 8'hFD;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hFE;

  // Counter width able to hold max_clks-1; never zero bits wide.
  function automatic int timer_width(input int max_clks);
    return (max_clks > 1) ? $clog2(max_clks) : 1;
  endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Saturating timeout counter shared by the inter-byte and response timers;
// limit_sel picks which limit the one-cycle expired pulse is measured against.
module cmd_timeout_counter
  import uart_cmd_pkg::*;
#(
  parameter int LIMIT_A = 5_000_000,
  parameter int LIMIT_B = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic limit_sel,
  output logic expired
);

  localparam int MAX_LIMIT = (LIMIT_A > LIMIT_B) ? LIMIT_A : LIMIT_B;
  localparam int W = timer_width(MAX_LIMIT);
  localparam logic [W-1:0] LAST_A = W'(LIMIT_A - 1);
  localparam logic [W-1:0] LAST_B = W'(LIMIT_B - 1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic [W-1:0] last_sel;

  assign last_sel = limit_sel ? LAST_B : LAST_A;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && (count_reg != '1)) begin
      count_next = count_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // The count passes the selected limit exactly once, so this is a pulse.
  assign expired = enable && (count_reg == last_sel);

endmodule

// File: rtl/uart_cmd_controller.sv
// Request/response sequencer between uart_rx/uart_tx and the device port:
// collects (cmd, addr), issues a valid/ready request, returns (code, data).
module uart_cmd_controller
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_BYTE_TIMEOUT = 5_000_000,
  parameter int CLKS_RSP_TIMEOUT  = 50_000_000,
  parameter int NUM_DEVICES       = 32
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Req_Valid,
  output logic [7:0] o_Req_Cmd,
  output logic [7:0] o_Req_Addr,
  input  logic       i_Req_Ready,
  input  logic       i_Rsp_Valid,
  input  logic [7:0] i_Rsp_Code,
  input  logic [7:0] i_Rsp_Data,
  output logic       o_Busy
);

  localparam logic [8:0] NUM_DEV = 9'(NUM_DEVICES);

  state_t     state_reg, state_next;
  logic [7:0] cmd_reg, cmd_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] code_reg, code_next;
  logic [7:0] data_reg, data_next;
  logic       tx_dv_reg, tx_dv_next;
  logic [7:0] tx_byte_reg, tx_byte_next;
  logic       req_valid_reg, req_valid_next;
  logic       busy_reg, busy_next;

  logic timer_clear;
  logic timer_enable;
  logic timer_sel;
  logic timer_expired;

  cmd_timeout_counter #(
    .LIMIT_A (CLKS_BYTE_TIMEOUT),
    .LIMIT_B (CLKS_RSP_TIMEOUT)
  ) u_timer (
    .clk       (i_Clock),
    .rst_n     (i_Rst_n),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .limit_sel (timer_sel),
    .expired   (timer_expired)
  );

  // One physical counter: byte limit in GET_ADDR, response limit in WAIT_RSP.
  assign timer_enable = (state_reg == GET_ADDR) || (state_reg == WAIT_RSP);
  assign timer_sel    = (state_reg == WAIT_RSP);
  assign timer_clear  = (state_next != state_reg);

  always_comb begin
    state_next   = state_reg;
    cmd_next     = cmd_reg;
    addr_next    = addr_reg;
    code_next    = code_reg;
    data_next    = data_reg;
    tx_dv_next   = 1'b0;
    tx_byte_next = tx_byte_reg;

    unique case (state_reg)
      IDLE: begin
        if (i_Rx_DV) begin
          cmd_next   = i_Rx_Byte;
          state_next = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (i_Rx_DV) begin
          addr_next = i_Rx_Byte;
          if ({1'b0, i_Rx_Byte} >= NUM_DEV) begin
            code_next  = RSP_BAD_ADDR;
            data_next  = i_Rx_Byte;
            state_next = SEND_CODE;
          end else begin
            state_next = ISSUE;
          end
        end else if (timer_expired) begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (req_valid_reg && i_Req_Ready) begin
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response landing on the timeout cycle takes priority.
        if (i_Rsp_Valid) begin
          code_next  = i_Rsp_Code;
          data_next  = i_Rsp_Data;
          state_next = SEND_CODE;
        end else if (timer_expired) begin
          code_next  = RSP_TIMEOUT;
          data_next  = 8'h00;
          state_next = SEND_CODE;
        end
      end
      WAIT_CODE: begin
        if (i_Tx_Done) begin
          state_next = SEND_DATA;
        end
      end
      WAIT_DATA: begin
        if (i_Tx_Done) begin
          state_next = IDLE;
        end
      end
      default: begin
        // SEND_CODE / SEND_DATA are resolved by the launch logic below.
      end
    endcase

    // Launch a byte as soon as the transmitter is free, including on the
    // cycle a SEND state is being entered, so o_Tx_DV trails i_Rsp_Valid
    // by a single clock when the transmitter is idle.
    if ((state_next == SEND_CODE) && !i_Tx_Active) begin
      tx_dv_next   = 1'b1;
      tx_byte_next = code_next;
      state_next   = WAIT_CODE;
    end else if ((state_next == SEND_DATA) && !i_Tx_Active) begin
      tx_dv_next   = 1'b1;
      tx_byte_next = data_next;
      state_next   = WAIT_DATA;
    end

    req_valid_next = (state_next == ISSUE);
    busy_next      = (state_next != IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg     <= IDLE;
      cmd_reg       <= 8'h00;
      addr_reg      <= 8'h00;
      code_reg      <= 8'h00;
      data_reg      <= 8'h00;
      tx_dv_reg     <= 1'b0;
      tx_byte_reg   <= 8'h00;
      req_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      addr_reg      <= addr_next;
      code_reg      <= code_next;
      data_reg      <= data_next;
      tx_dv_reg     <= tx_dv_next;
      tx_byte_reg   <= tx_byte_next;
      req_valid_reg <= req_valid_next;
      busy_reg      <= busy_next;
    end
  end

  assign o_Tx_DV     = tx_dv_reg;
  assign o_Tx_Byte   = tx_byte_reg;
  assign o_Req_Valid = req_valid_reg;
  assign o_Req_Cmd   = cmd_reg;
  assign o_Req_Addr  = addr_reg;
  assign o_Busy      = busy_reg;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Self-checking bench for uart_cmd_controller: scoreboard of expected
// requests/tx bytes against what a negedge monitor observes.
module tb_uart_cmd_controller;

  localparam int BYTE_TO = 50;
  localparam int RSP_TO  = 100;
  localparam int NDEV    = 32;
  localparam int TX_LEN  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done = 1'b0;
  logic       req_valid;
  logic [7:0] req_cmd;
  logic [7:0] req_addr;
  logic       req_ready = 1'b0;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_code = 8'h00;
  logic [7:0] rsp_data = 8'h00;
  logic       busy;

  always #5 clk = ~clk;

  uart_cmd_controller #(
    .CLKS_BYTE_TIMEOUT (BYTE_TO),
    .CLKS_RSP_TIMEOUT  (RSP_TO),
    .NUM_DEVICES       (NDEV)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Req_Valid (req_valid),
    .o_Req_Cmd   (req_cmd),
    .o_Req_Addr  (req_addr),
    .i_Req_Ready (req_ready),
    .i_Rsp_Valid (rsp_valid),
    .i_Rsp_Code  (rsp_code),
    .i_Rsp_Data  (rsp_data),
    .o_Busy      (busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Items: {1'b1, cmd, addr} for an accepted request, {1'b0, 8'h00, byte} for a tx byte.
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];

  logic       tx_busy = 1'b0;
  logic       tx_block = 1'b0;
  logic       prev_dv = 1'b0;
  logic [7:0] tx_held = 8'h00;
  int         tx_cnt = 0;
  int         tx_pulses = 0;
  int         tx_dones = 0;
  int         hs_cnt = 0;
  int         req_valid_cycles = 0;
  int         proto_err = 0;

  assign tx_active = tx_busy | tx_block;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_busy = 1'b0;
      tx_done = 1'b0;
      tx_cnt  = 0;
      prev_dv = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (req_valid) req_valid_cycles++;
      if (req_valid && req_ready) begin
        obs_q.push_back({1'b1, req_cmd, req_addr});
        hs_cnt++;
      end
      if (tx_dv) begin
        if (prev_dv || tx_busy) begin
          proto_err++;
        end else begin
          obs_q.push_back({1'b0, 8'h00, tx_byte});
          tx_pulses++;
          tx_held = tx_byte;
          tx_busy = 1'b1;
          tx_cnt  = TX_LEN;
        end
      end else if (tx_busy) begin
        if (tx_byte !== tx_held) proto_err++;
        if (tx_cnt == 0) begin
          tx_busy = 1'b0;
          tx_done = 1'b1;
          tx_dones++;
        end else begin
          tx_cnt--;
        end
      end
      prev_dv = tx_dv;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_rx(input logic [7:0] b);
    step();
    rx_dv   = 1'b1;
    rx_byte = b;
    step();
    rx_dv   = 1'b0;
  endtask

  task automatic pulse_rsp(input logic [7:0] c, input logic [7:0] d);
    rsp_valid = 1'b1;
    rsp_code  = c;
    rsp_data  = d;
    step();
    rsp_valid = 1'b0;
  endtask

  task automatic handshake();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      step();
      n++;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if ({tx_dv, tx_byte, req_valid, req_cmd, req_addr, busy} !== 26'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %07h, expected 0000000",
               {tx_dv, tx_byte, req_valid, req_cmd, req_addr, busy});
    end
    rst_n = 1'b1;
    repeat (2) step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %b, expected 0", busy);
    end
    $display("reset: outputs cleared, idle after release");
  endtask

  task automatic test_normal();
    int h0 = hs_cnt;
    int d0 = tx_dones;
    bit ok;
    logic [16:0] e, o;
    exp_q.push_back({1'b1, 8'h01, 8'h05});
    exp_q.push_back({1'b0, 8'h00, 8'h00});
    exp_q.push_back({1'b0, 8'h00, 8'h1A});
    send_rx(8'h01);
    vectors++;
    if ({busy, req_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL normal_get_addr: busy,valid=%b, expected 10", {busy, req_valid});
    end
    send_rx(8'h05);
    vectors++;
    if (req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL normal_req_latency: valid=%b, expected 1", req_valid);
    end
    step();
    step();
    handshake();
    vectors++;
    if (req_valid !== 1'b0 || hs_cnt - h0 != 1) begin
      miscompares++;
      $display("FAIL normal_handshake: valid=%b accepts=%0d, expected 0 and 1", req_valid, hs_cnt - h0);
    end
    repeat (3) step();
    pulse_rsp(8'h00, 8'h1A);
    vectors++;
    if ({tx_dv, tx_byte} !== 9'h100) begin
      miscompares++;
      $display("FAIL normal_tx_latency: dv,byte=%03h, expected 100", {tx_dv, tx_byte});
    end
    wait_idle(200, ok);
    vectors++;
    if (!ok || tx_dones - d0 != 2) begin
      miscompares++;
      $display("FAIL normal_busy_fall: idle=%b dones=%0d, expected 1 and 2", ok, tx_dones - d0);
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL normal_count: observed %0d items, expected %0d", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL normal_item: got %05h, expected %05h", o, e);
        end
      end
    end
    $display("normal: cmd 01 addr 05 -> code 00 data 1a");
  endtask

  task automatic test_bad_addr();
    int h0 = hs_cnt;
    int v0 = req_valid_cycles;
    int t0 = tx_pulses;
    bit ok;
    logic [16:0] e, o;
    exp_q.push_back({1'b0, 8'h00, 8'hFD});
    exp_q.push_back({1'b0, 8'h00, 8'h20});
    send_rx(8'h01);
    send_rx(8'h20);
    wait_idle(200, ok);
    vectors++;
    if (!ok || hs_cnt != h0 || req_valid_cycles != v0 || tx_pulses - t0 != 2) begin
      miscompares++;
      $display("FAIL bad_addr_flow: idle=%b valid_cycles=%0d tx=%0d, expected 1, 0, 2",
               ok, req_valid_cycles - v0, tx_pulses - t0);
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL bad_addr_count: observed %0d items, expected %0d", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL bad_addr_item: got %05h, expected %05h", o, e);
        end
      end
    end
    $display("bad_addr: cmd 01 addr 20 -> code fd data 20");
  endtask

  task automatic test_rsp_timeout();
    int hs_cyc;
    int dv_cyc = -1;
    int n = 0;
    bit ok;
    logic [16:0] e, o;
    exp_q.push_back({1'b1, 8'h02, 8'h03});
    exp_q.push_back({1'b0, 8'h00, 8'hFE});
    exp_q.push_back({1'b0, 8'h00, 8'h00});
    send_rx(8'h02);
    send_rx(8'h03);
    handshake();
    hs_cyc = cyc;
    while (dv_cyc < 0 && n < 300) begin
      step();
      n++;
      if (tx_dv) dv_cyc = cyc;
    end
    vectors++;
    if (dv_cyc - hs_cyc != RSP_TO) begin
      miscompares++;
      $display("FAIL rsp_timeout_delay: got %0d clocks, expected %0d", dv_cyc - hs_cyc, RSP_TO);
    end
    wait_idle(200, ok);
    // Response arriving on the very cycle the timer expires.
    exp_q.push_back({1'b1, 8'h02, 8'h04});
    exp_q.push_back({1'b0, 8'h00, 8'h5A});
    exp_q.push_back({1'b0, 8'h00, 8'h77});
    send_rx(8'h02);
    send_rx(8'h04);
    handshake();
    repeat (RSP_TO - 1) step();
    pulse_rsp(8'h5A, 8'h77);
    vectors++;
    if ({tx_dv, tx_byte} !== 9'h15A) begin
      miscompares++;
      $display("FAIL rsp_same_cycle: dv,byte=%03h, expected 15a", {tx_dv, tx_byte});
    end
    wait_idle(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rsp_timeout_idle: busy never fell, expected idle");
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_timeout_count: observed %0d items, expected %0d", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL rsp_timeout_item: got %05h, expected %05h", o, e);
        end
      end
    end
    $display("rsp_timeout: cmd 02 addr 03 -> fe 00; same-cycle cmd 02 addr 04 -> 5a 77");
  endtask

  task automatic test_byte_timeout();
    int t0 = tx_pulses;
    int h0 = hs_cnt;
    int start;
    bit ok;
    logic [16:0] e, o;
    send_rx(8'h01);
    start = cyc;
    wait_idle(200, ok);
    vectors++;
    if (!ok || cyc - start != BYTE_TO || tx_pulses != t0 || hs_cnt != h0) begin
      miscompares++;
      $display("FAIL byte_timeout: idle=%b after %0d clocks tx=%0d, expected 1 after %0d clocks tx=0",
               ok, cyc - start, tx_pulses - t0, BYTE_TO);
    end
    exp_q.push_back({1'b1, 8'h03, 8'h02});
    exp_q.push_back({1'b0, 8'h00, 8'h00});
    exp_q.push_back({1'b0, 8'h00, 8'h42});
    send_rx(8'h03);
    send_rx(8'h02);
    handshake();
    step();
    pulse_rsp(8'h00, 8'h42);
    wait_idle(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL byte_timeout_recover: busy never fell, expected idle");
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL byte_timeout_count: observed %0d items, expected %0d", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL byte_timeout_item: got %05h, expected %05h", o, e);
        end
      end
    end
    $display("byte_timeout: lone 01 dropped; cmd 03 addr 02 -> 00 42");
  endtask

  task automatic test_back_to_back();
    int t0 = tx_pulses;
    int h0 = hs_cnt;
    int n = 0;
    bit ok;
    logic [16:0] e, o;
    exp_q.push_back({1'b1, 8'h04, 8'h1F});
    exp_q.push_back({1'b0, 8'h00, 8'h00});
    exp_q.push_back({1'b0, 8'h00, 8'h99});
    send_rx(8'h04);
    send_rx(8'h1F);
    vectors++;
    if (req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_last_addr: valid=%b, expected 1", req_valid);
    end
    handshake();
    send_rx(8'h55);
    tx_block = 1'b1;
    pulse_rsp(8'h00, 8'h99);
    for (int i = 0; i < 19; i++) begin
      vectors++;
      if (tx_dv !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold: tx_dv=%b at blocked cycle %0d, expected 0", tx_dv, i);
      end
      step();
    end
    tx_block = 1'b0;
    step();
    vectors++;
    if ({tx_dv, tx_byte} !== 9'h100) begin
      miscompares++;
      $display("FAIL backpressure_release: dv,byte=%03h, expected 100", {tx_dv, tx_byte});
    end
    while (tx_pulses - t0 < 2 && n < 100) begin
      step();
      n++;
    end
    send_rx(8'h66);
    wait_idle(200, ok);
    repeat (5) step();
    vectors++;
    if (!ok || busy !== 1'b0 || hs_cnt - h0 != 1 || tx_pulses - t0 != 2) begin
      miscompares++;
      $display("FAIL backpressure_drop: idle=%b busy=%b accepts=%0d tx=%0d, expected 1, 0, 1, 2",
               ok, busy, hs_cnt - h0, tx_pulses - t0);
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL backpressure_count: observed %0d items, expected %0d", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL backpressure_item: got %05h, expected %05h", o, e);
        end
      end
    end
    $display("back_to_back: cmd 04 addr 1f -> 00 99 with stray rx 55/66 ignored");
  endtask

  task automatic test_async_reset();
    int t0;
    int n = 0;
    bit ok;
    logic [16:0] e, o;
    // The data byte of this transaction is never sent: reset aborts it.
    exp_q.push_back({1'b1, 8'h06, 8'h01});
    exp_q.push_back({1'b0, 8'h00, 8'h00});
    send_rx(8'h06);
    send_rx(8'h01);
    handshake();
    step();
    pulse_rsp(8'h00, 8'h0B);
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({tx_dv, tx_byte, req_valid, req_cmd, req_addr, busy} !== 26'b0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %07h, expected 0000000",
               {tx_dv, tx_byte, req_valid, req_cmd, req_addr, busy});
    end
    step();
    step();
    rst_n = 1'b1;
    t0 = tx_pulses;
    exp_q.push_back({1'b1, 8'h01, 8'h10});
    exp_q.push_back({1'b0, 8'h00, 8'h00});
    exp_q.push_back({1'b0, 8'h00, 8'hC3});
    repeat (3) step();
    send_rx(8'h01);
    send_rx(8'h10);
    while (!req_valid && n < 10) begin
      step();
      n++;
    end
    handshake();
    step();
    pulse_rsp(8'h00, 8'hC3);
    wait_idle(200, ok);
    vectors++;
    if (!ok || tx_pulses - t0 != 2) begin
      miscompares++;
      $display("FAIL async_reset_recover: idle=%b tx=%0d, expected 1 and 2", ok, tx_pulses - t0);
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL async_reset_count: observed %0d items, expected %0d", obs_q.size(), exp_q.size());
        exp_q.delete();
        obs_q.delete();
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL async_reset_item: got %05h, expected %05h", o, e);
        end
      end
    end
    $display("async_reset: aborted in WAIT_CODE; cmd 01 addr 10 -> 00 c3");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_addr();
    test_rsp_timeout();
    test_byte_timeout();
    test_back_to_back();
    test_async_reset();
    vectors++;
    if (proto_err != 0) begin
      miscompares++;
      $display("FAIL tx_protocol: %0d violations, expected 0", proto_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
